axi_lite_slave_regs: RTL and testbench
======================================

# axi_lite_slave_regs

AXI4-Lite responder exposing `NUM_REGS` 32-bit read/write registers in a fixed address window. It sits on one slave port of the AXI4-Lite interconnect. Read and write channels run independently, and AW and W may arrive in either order. Register contents are driven out flat for hardware consumption, with a one-cycle strobe per register on every committed write.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, address width.
- `NUM_REGS`, 4, number of 32-bit registers; must be ≥1.
- `BASE_ADDR`, 32'h0, byte address of register 0; must be 4-byte aligned.

Ports:
- `aclk`  in  1  clock; all logic on the rising edge.
- `areset_n`  in  1  reset, asynchronous, active-low.
- `axis`  modport `axi_lite_if.slave`  —  responder side of the bus. It carries `araddr`, `arvalid`, `arready`, `rdata[31:0]`, `rresp[1:0]`, `rvalid`, `rready`, `awaddr`, `awvalid`, `awready`, `wdata[31:0]`, `wstrb[3:0]`, `wvalid`, `wready`, `bresp[1:0]`, `bvalid`, `bready`.
- `regs_o`  out  32*NUM_REGS  register contents; register i is at bits [32i+31:32i].
- `wr_pulse_o`  out  NUM_REGS  bit i is high for one cycle after a committed in-range write to register i.

## Operation
- **Decode**
  - An address is in range iff `BASE_ADDR <= addr < BASE_ADDR + 4*NUM_REGS`.
  - Index = `(addr - BASE_ADDR) >> 2`. `addr[1:0]` is ignored.
- **Write path**
  - Each channel has its own hold register: `aw_held` plus address, and `w_held` plus data/strobe.
  - `awready = !aw_held && !bvalid`; `wready = !w_held && !bvalid`.
  - Commit occurs at the edge where both AW and W are available. Each is available either because it is already held or because it handshakes on that edge.
  - In range: each byte lane with `wstrb[b]=1` is updated and the other lanes are kept. `bresp` = OKAY (2'b00). The matching `wr_pulse_o` bit is set, even when `wstrb` = 0.
  - Out of range: no register changes, no pulse, `bresp` = SLVERR (2'b10).
  - On commit: `bvalid` goes to 1 and both held flags clear. `bvalid` and `bresp` stay stable until `bvalid && bready`, after which `bvalid` goes to 0.
- **Read path**
  - `arready = !rvalid`.
  - On the AR handshake edge, the following are registered:
    - In range: `rdata` = register value and `rresp` = OKAY.
    - Out of range: `rdata` = 0 and `rresp` = SLVERR.
  - `rvalid` goes to 1 on that edge. `rdata`, `rresp` and `rvalid` are held until `rvalid && rready`.
- **Simultaneous events**
  - A read and a write to the same register committing on the same edge: the read returns the pre-write value.
  - AW, W and a B retire (`bvalid && bready`) on the same edge cannot occur, because the readies are low while `bvalid` is high.

## Timing
- **Reset values (async, immediate)**
  - All registers 0, `regs_o` = 0, `wr_pulse_o` = 0.
  - `bvalid` = 0, `bresp` = 0, `rvalid` = 0, `rdata` = 0, `rresp` = 0.
  - `aw_held` = `w_held` = 0, so `awready` = `wready` = `arready` = 1.
- **Write latency**
  - `bvalid` is high in the first cycle after the later of the AW and W handshakes.
  - `regs_o` and `wr_pulse_o` update in that same cycle.
- **Read latency:** `rvalid` is high in the first cycle after the AR handshake.
- **Throughput**
  - One write per 2 cycles when `bready` is held high.
  - One read per 2 cycles when `rready` is held high.
- **Reset mid-transaction:** held AW/W and pending B/R are discarded. No response is issued after reset deasserts.
- **Ready dependency:** ready signals never depend combinationally on the corresponding `*valid`.

## Structure
- **`axi_lite_pkg`**
  - Add `axi_resp_t` enum: `RESP_OKAY` = 2'b00, `RESP_SLVERR` = 2'b10, `RESP_DECERR` = 2'b11.
  - Add `AXI_DATA_W` = 32 and `AXI_STRB_W` = 4.
- **Sub-module `axi_lite_addr_decode`**
  - Combinational, parameterised by `BASE_ADDR` and `NUM_REGS`.
  - Outputs `hit` and `index`.
  - Instantiated twice: once for the held/incoming write address and once for `araddr`.
- Write and read paths are separate `always_ff` blocks inside `axi_lite_slave_regs`.

## Test plan
- **Write then read.** AW 0x4 and W 0xDEADBEEF with strb 4'hF in the same cycle, `bready` = 1. Required: `bvalid` 1 cycle later with OKAY; `regs_o[63:32]` = 0xDEADBEEF; `wr_pulse_o` = 4'b0010. Then AR 0x4 gives `rdata` = 0xDEADBEEF with OKAY one cycle after the handshake.
- **W before AW, partial strobe.** W 0x11223344 strb 4'b0101 at cycle 0, AW 0x8 at cycle 3. Required: `wready` low during cycles 1–3; `bvalid` at cycle 4; reg2 = 0x00220044 starting from 0.
- **Out of range.** AW 0x10 with W data, and AR 0x14. Required: `bresp` = 2'b10 with no register change and no pulse; `rdata` = 0 with `rresp` = 2'b10.
- **Backpressure.** `bready` = 0 and `rready` = 0 for 5 cycles after a response. Required: `bvalid`/`bresp` and `rvalid`/`rdata` stay stable; `awready`, `wready` and `arready` stay low; each drops one cycle after its ready is raised.
- **Same-edge hazard.** Reg0 = 0xA, then the write of 0xB to 0x0 commits on the same edge as AR 0x0. Required: `rdata` = 0xA, with reg0 = 0xB afterward.
- **Reset mid-write.** AW accepted, then `areset_n` is low for 1 cycle before W. Required: outputs go to reset values immediately. A later W alone produces no `bvalid`.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared AXI4-Lite types, widths and sizing helper
package axi_lite_pkg;

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10,
        RESP_DECERR = 2'b11
    } axi_resp_t;

    localparam int AXI_DATA_W = 32;
    localparam int AXI_STRB_W = 4;

    // A single register still needs a one-bit index so port widths stay legal.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/axi_lite_if.sv
// rtl/axi_lite_if.sv - AXI4-Lite bus bundle with master and slave views
interface axi_lite_if
    import axi_lite_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  arvalid;
    logic                  arready;
    logic [AXI_DATA_W-1:0] rdata;
    logic [1:0]            rresp;
    logic                  rvalid;
    logic                  rready;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  awvalid;
    logic                  awready;
    logic [AXI_DATA_W-1:0] wdata;
    logic [AXI_STRB_W-1:0] wstrb;
    logic                  wvalid;
    logic                  wready;
    logic [1:0]            bresp;
    logic                  bvalid;
    logic                  bready;

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/axi_lite_addr_decode.sv
// rtl/axi_lite_addr_decode.sv - maps a byte address onto the register window
module axi_lite_addr_decode #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    NUM_REGS   = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter int                    IDX_W      = 2
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic                  hit,
    output logic [IDX_W-1:0]      index
);
    // One extra bit keeps the span compare correct when the window ends at the top of memory.
    localparam logic [ADDR_WIDTH:0] SPAN = (ADDR_WIDTH+1)'(4 * NUM_REGS);

    logic [ADDR_WIDTH-1:0] offset;

    assign offset = addr - BASE_ADDR;
    assign hit    = (addr >= BASE_ADDR) && ({1'b0, offset} < SPAN);
    assign index  = offset[IDX_W+1:2];
endmodule

// File: rtl/axi_lite_slave_regs.sv
// rtl/axi_lite_slave_regs.sv - AXI4-Lite register bank with independent read and write paths
module axi_lite_slave_regs
    import axi_lite_pkg::*;
#(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    NUM_REGS   = 4,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
    input  logic                     aclk,
    input  logic                     areset_n,
    axi_lite_if.slave                axis,
    output logic [32*NUM_REGS-1:0]   regs_o,
    output logic [NUM_REGS-1:0]      wr_pulse_o
);
    localparam int IDX_W = idx_w(NUM_REGS);

    logic [AXI_DATA_W-1:0] regs_q [NUM_REGS];
    logic [AXI_DATA_W-1:0] regs_d [NUM_REGS];
    logic                  aw_held_q, aw_held_d;
    logic [ADDR_WIDTH-1:0] aw_addr_q, aw_addr_d;
    logic                  w_held_q, w_held_d;
    logic [AXI_DATA_W-1:0] w_data_q, w_data_d;
    logic [AXI_STRB_W-1:0] w_strb_q, w_strb_d;
    logic                  bvalid_q, bvalid_d;
    axi_resp_t             bresp_q, bresp_d;
    logic [NUM_REGS-1:0]   wr_pulse_q, wr_pulse_d;
    logic                  rvalid_q, rvalid_d;
    logic [AXI_DATA_W-1:0] rdata_q, rdata_d;
    axi_resp_t             rresp_q, rresp_d;

    logic                  aw_hs, w_hs, ar_hs, commit;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [AXI_DATA_W-1:0] wr_data;
    logic [AXI_STRB_W-1:0] wr_strb;
    logic                  wr_hit, rd_hit;
    logic [IDX_W-1:0]      wr_idx, rd_idx;

    assign axis.awready = !aw_held_q && !bvalid_q;
    assign axis.wready  = !w_held_q && !bvalid_q;
    assign axis.arready = !rvalid_q;
    assign axis.bvalid  = bvalid_q;
    assign axis.bresp   = bresp_q;
    assign axis.rvalid  = rvalid_q;
    assign axis.rdata   = rdata_q;
    assign axis.rresp   = rresp_q;
    assign wr_pulse_o   = wr_pulse_q;

    assign aw_hs  = axis.awvalid && axis.awready;
    assign w_hs   = axis.wvalid && axis.wready;
    assign ar_hs  = axis.arvalid && axis.arready;
    assign commit = (aw_held_q || aw_hs) && (w_held_q || w_hs);

    // A held beat takes priority; otherwise the beat handshaking this edge is used directly.
    assign wr_addr = aw_held_q ? aw_addr_q : axis.awaddr;
    assign wr_data = w_held_q ? w_data_q : axis.wdata;
    assign wr_strb = w_held_q ? w_strb_q : axis.wstrb;

    axi_lite_addr_decode #(
        .ADDR_WIDTH(ADDR_WIDTH), .NUM_REGS(NUM_REGS), .BASE_ADDR(BASE_ADDR), .IDX_W(IDX_W)
    ) u_wr_decode (
        .addr(wr_addr), .hit(wr_hit), .index(wr_idx)
    );

    axi_lite_addr_decode #(
        .ADDR_WIDTH(ADDR_WIDTH), .NUM_REGS(NUM_REGS), .BASE_ADDR(BASE_ADDR), .IDX_W(IDX_W)
    ) u_rd_decode (
        .addr(axis.araddr), .hit(rd_hit), .index(rd_idx)
    );

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
        assign regs_o[32*i +: 32] = regs_q[i];
    end

    always_comb begin
        aw_held_d  = aw_held_q;
        aw_addr_d  = aw_addr_q;
        w_held_d   = w_held_q;
        w_data_d   = w_data_q;
        w_strb_d   = w_strb_q;
        bvalid_d   = bvalid_q;
        bresp_d    = bresp_q;
        regs_d     = regs_q;
        wr_pulse_d = '0;
        if (bvalid_q && axis.bready) begin
            bvalid_d = 1'b0;
        end
        if (aw_hs) begin
            aw_held_d = 1'b1;
            aw_addr_d = axis.awaddr;
        end
        if (w_hs) begin
            w_held_d = 1'b1;
            w_data_d = axis.wdata;
            w_strb_d = axis.wstrb;
        end
        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = wr_hit ? RESP_OKAY : RESP_SLVERR;
            if (wr_hit) begin
                for (int b = 0; b < AXI_STRB_W; b++) begin
                    if (wr_strb[b]) begin
                        regs_d[wr_idx][8*b +: 8] = wr_data[8*b +: 8];
                    end
                end
                wr_pulse_d[wr_idx] = 1'b1;
            end
        end
    end

    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        if (rvalid_q && axis.rready) begin
            rvalid_d = 1'b0;
        end
        // Reads sample regs_q, so a same-edge write is not visible to this read.
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = rd_hit ? regs_q[rd_idx] : '0;
            rresp_d  = rd_hit ? RESP_OKAY : RESP_SLVERR;
        end
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            aw_held_q  <= 1'b0;
            aw_addr_q  <= '0;
            w_held_q   <= 1'b0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            wr_pulse_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            aw_held_q  <= aw_held_d;
            aw_addr_q  <= aw_addr_d;
            w_held_q   <= w_held_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            bvalid_q   <= bvalid_d;
            bresp_q    <= bresp_d;
            wr_pulse_q <= wr_pulse_d;
            regs_q     <= regs_d;
        end
    end

    always_ff @(posedge aclk or negedge areset_n) begin
        if (!areset_n) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else begin
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            rresp_q  <= rresp_d;
        end
    end
endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// tb/tb_axi_lite_slave_regs.sv - directed scoreboard bench for axi_lite_slave_regs
module tb_axi_lite_slave_regs;
    logic         aclk = 1'b0;
    logic         areset_n = 1'b0;
    logic [127:0] regs_o;
    logic [3:0]   wr_pulse_o;

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl [4];
    logic [1:0]  exp_b [$];
    logic [33:0] exp_r [$];

    axi_lite_if #(.ADDR_WIDTH(32)) bus ();

    axi_lite_slave_regs #(.ADDR_WIDTH(32), .NUM_REGS(4), .BASE_ADDR(32'h0)) dut (
        .aclk(aclk), .areset_n(areset_n), .axis(bus),
        .regs_o(regs_o), .wr_pulse_o(wr_pulse_o)
    );

    always #5 aclk = ~aclk;

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] flat();
        return {mdl[3], mdl[2], mdl[1], mdl[0]};
    endfunction

    function automatic logic [1:0] pop_b();
        if (exp_b.size() == 0) return 2'bxx;
        return exp_b.pop_front();
    endfunction

    function automatic logic [33:0] pop_r();
        if (exp_r.size() == 0) return 34'bx;
        return exp_r.pop_front();
    endfunction

    task automatic model_write(input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, output logic [3:0] pulse);
        int idx;
        pulse = 4'b0000;
        if (addr < 32'h10) begin
            idx = int'(addr >> 2);
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) mdl[idx][8*b +: 8] = data[8*b +: 8];
            end
            pulse[idx] = 1'b1;
            exp_b.push_back(2'b00);
        end else begin
            exp_b.push_back(2'b10);
        end
    endtask

    task automatic model_read(input logic [31:0] addr);
        if (addr < 32'h10) exp_r.push_back({2'b00, mdl[int'(addr >> 2)]});
        else               exp_r.push_back({2'b10, 32'h0});
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
        logic [3:0] pulse;
        bus.awaddr = addr; bus.awvalid = 1'b1;
        bus.wdata = data; bus.wstrb = strb; bus.wvalid = 1'b1;
        bus.bready = 1'b1;
        model_write(addr, data, strb, pulse);
        tick();
        bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        chk("wr_bvalid", 128'(bus.bvalid), 128'(1));
        chk("wr_bresp", 128'(bus.bresp), 128'(pop_b()));
        chk("wr_regs", regs_o, flat());
        chk("wr_pulse", 128'(wr_pulse_o), 128'(pulse));
        tick();
        chk("wr_bretire", 128'(bus.bvalid), 128'(0));
        chk("wr_pulse_clr", 128'(wr_pulse_o), 128'(0));
    endtask

    task automatic do_read(input logic [31:0] addr);
        model_read(addr);
        bus.araddr = addr; bus.arvalid = 1'b1; bus.rready = 1'b1;
        tick();
        bus.arvalid = 1'b0;
        chk("rd_rvalid", 128'(bus.rvalid), 128'(1));
        chk("rd_resp_data", 128'({bus.rresp, bus.rdata}), 128'(pop_r()));
        tick();
        chk("rd_rretire", 128'(bus.rvalid), 128'(0));
    endtask

    initial begin
        logic [1:0]  bp_bresp;
        logic [33:0] bp_r;
        logic [3:0]  pulse;
        for (int i = 0; i < 4; i++) mdl[i] = 32'h0;
        bus.araddr = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        bus.awaddr = '0; bus.awvalid = 1'b0;
        bus.wdata = '0; bus.wstrb = '0; bus.wvalid = 1'b0; bus.bready = 1'b0;

        tick();
        tick();
        chk("rst_regs", regs_o, 128'h0);
        chk("rst_pulse", 128'(wr_pulse_o), 128'h0);
        chk("rst_valids", 128'({bus.bvalid, bus.rvalid}), 128'h0);
        chk("rst_resp_data", 128'({bus.bresp, bus.rresp, bus.rdata}), 128'h0);
        chk("rst_readies", 128'({bus.awready, bus.wready, bus.arready}), 128'h7);
        areset_n = 1'b1;
        tick();

        do_write(32'h4, 32'hDEADBEEF, 4'hF);
        do_read(32'h4);

        // W first, AW three cycles later
        bus.wdata = 32'h11223344; bus.wstrb = 4'b0101; bus.wvalid = 1'b1; bus.bready = 1'b1;
        tick();
        bus.wvalid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            chk("wfirst_wready_low", 128'(bus.wready), 128'(0));
            chk("wfirst_no_b", 128'(bus.bvalid), 128'(0));
            if (c == 3) begin
                bus.awaddr = 32'h8; bus.awvalid = 1'b1;
                model_write(32'h8, 32'h11223344, 4'b0101, pulse);
            end
            tick();
        end
        bus.awvalid = 1'b0;
        chk("wfirst_bvalid", 128'(bus.bvalid), 128'(1));
        chk("wfirst_bresp", 128'(bus.bresp), 128'(pop_b()));
        chk("wfirst_reg2", 128'(regs_o[95:64]), 128'h00220044);
        chk("wfirst_pulse", 128'(wr_pulse_o), 128'(pulse));
        tick();

        do_write(32'h10, 32'hCAFEF00D, 4'hF);
        do_read(32'h14);

        // both responses held under backpressure
        bus.bready = 1'b0; bus.rready = 1'b0;
        model_read(32'h0);
        bus.araddr = 32'h0; bus.arvalid = 1'b1;
        bus.awaddr = 32'hC; bus.wdata = 32'h00000055; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        model_write(32'hC, 32'h00000055, 4'hF, pulse);
        tick();
        bus.arvalid = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        bp_bresp = pop_b();
        bp_r = pop_r();
        for (int c = 0; c < 5; c++) begin
            chk("bp_b", 128'({bus.bvalid, bus.bresp}), 128'({1'b1, bp_bresp}));
            chk("bp_r", 128'({bus.rvalid, bus.rresp, bus.rdata}), 128'({1'b1, bp_r}));
            chk("bp_readies", 128'({bus.awready, bus.wready, bus.arready}), 128'h0);
            tick();
        end
        chk("bp_regs", regs_o, flat());
        bus.bready = 1'b1;
        tick();
        chk("bp_b_drop", 128'(bus.bvalid), 128'(0));
        chk("bp_aw_w_ready", 128'({bus.awready, bus.wready}), 128'h3);
        chk("bp_r_still", 128'(bus.rvalid), 128'(1));
        bus.rready = 1'b1;
        tick();
        chk("bp_r_drop", 128'({bus.rvalid, bus.arready}), 128'h1);

        // write and read of reg0 on the same edge
        do_write(32'h0, 32'hA, 4'hF);
        model_read(32'h0);
        bus.araddr = 32'h0; bus.arvalid = 1'b1;
        bus.awaddr = 32'h0; bus.wdata = 32'hB; bus.wstrb = 4'hF;
        bus.awvalid = 1'b1; bus.wvalid = 1'b1;
        model_write(32'h0, 32'hB, 4'hF, pulse);
        tick();
        bus.arvalid = 1'b0; bus.awvalid = 1'b0; bus.wvalid = 1'b0;
        chk("hazard_rdata", 128'({bus.rvalid, bus.rresp, bus.rdata}), 128'({1'b1, pop_r()}));
        chk("hazard_b", 128'({bus.bvalid, bus.bresp}), 128'({1'b1, pop_b()}));
        chk("hazard_reg0", 128'(regs_o[31:0]), 128'hB);
        tick();

        // reset between AW and W
        bus.awaddr = 32'h4; bus.awvalid = 1'b1;
        tick();
        bus.awvalid = 1'b0;
        chk("rstmid_aw_held", 128'({bus.awready, bus.wready}), 128'h1);
        areset_n = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) mdl[i] = 32'h0;
        exp_b.delete();
        exp_r.delete();
        chk("rstmid_regs", regs_o, flat());
        chk("rstmid_readies", 128'({bus.awready, bus.wready, bus.arready}), 128'h7);
        chk("rstmid_valids", 128'({bus.bvalid, bus.rvalid, wr_pulse_o}), 128'h0);
        tick();
        areset_n = 1'b1;
        bus.wdata = 32'h12345678; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
        tick();
        bus.wvalid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            chk("rstmid_no_b", 128'(bus.bvalid), 128'(0));
            chk("rstmid_regs_kept", regs_o, flat());
            tick();
        end
        chk("rstmid_w_held", 128'(bus.wready), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
